// File: rtl/rcn_master.sv
// rcn_master: ring-bus initiator.
// Issues client read/write requests into free ring slots, tracks up to four
// outstanding tags, and strips its own responses and bounced requests off the
// ring, reporting them back to the client as one-cycle response strobes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rcn_in / rcn_out    69-bit ring input / registered ring output
//   req_valid/req_ready client request handshake (req_ready is combinational)
//   req_wr, req_mask, req_addr, req_wdata   request payload
//   req_seq             tag given to the request accepted this cycle
//   rsp_valid, rsp_err, rsp_seq, rsp_wr, rsp_addr, rsp_data   response strobe
//   busy                at least one transaction outstanding

module rcn_master #(
    parameter logic [5:0] MASTER_ID = 6'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [68:0] rcn_in,
    output logic [68:0] rcn_out,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [3:0]  req_mask,
    input  logic [23:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [1:0]  req_seq,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [1:0]  rsp_seq,
    output logic        rsp_wr,
    output logic [23:0] rsp_addr,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam int unsigned PKT_W  = 69;
    localparam int unsigned TAGS   = 4;
    localparam int unsigned SEQ_W  = 2;
    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 32;

    // Ring pipeline and tracking state
    logic [PKT_W-1:0]  rin_q;
    logic [PKT_W-1:0]  rout_q, rout_d;
    logic [TAGS-1:0]   pend_q, pend_d;
    logic [SEQ_W-1:0]  next_seq_q, next_seq_d;

    // Registered response outputs
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [SEQ_W-1:0]  rsp_seq_q, rsp_seq_d;
    logic              rsp_wr_q, rsp_wr_d;
    logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Field decode of the captured ring word
    logic              rin_vld;
    logic              rin_req;
    logic              rin_wr;
    logic [5:0]        rin_id;
    logic [21:0]       rin_waddr;
    logic [SEQ_W-1:0]  rin_seq;
    logic [DATA_W-1:0] rin_data;
    logic              own_rsp;
    logic              own_bounce;
    logic              own_pkt;
    logic              slot_free;
    logic              retire;
    logic              issue;

    // Byte-offset address bits are not carried on the ring.
    logic              unused_addr_lo;

    assign unused_addr_lo = ^req_addr[1:0];

    assign rin_vld   = rin_q[68];
    assign rin_req   = rin_q[67];
    assign rin_wr    = rin_q[66];
    assign rin_id    = rin_q[65:60];
    assign rin_waddr = rin_q[55:34];
    assign rin_seq   = rin_q[33:32];
    assign rin_data  = rin_q[31:0];

    assign own_rsp    = rin_vld & ~rin_req & (rin_id == MASTER_ID);
    assign own_bounce = rin_vld &  rin_req & (rin_id == MASTER_ID);
    assign own_pkt    = own_rsp | own_bounce;
    assign slot_free  = ~rin_vld | own_pkt;

    // Stray packets (tag not pending, e.g. from before a reset) are removed
    // but never reported.
    assign retire = own_pkt & pend_q[rin_seq];

    // Ready waits for the next tag to be free, so a same-cycle retire and
    // issue always touch different pend bits.
    assign req_ready = slot_free & ~pend_q[next_seq_q] & ~rst;
    assign issue     = req_valid & req_ready;
    assign req_seq   = next_seq_q;
    assign busy      = |pend_q;

    assign rcn_out   = rout_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_seq   = rsp_seq_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_addr  = rsp_addr_q;
    assign rsp_data  = rsp_data_q;

    // Next-state: slot insertion/removal, tag tracking, response capture
    always_comb begin
        rout_d      = rin_q;
        pend_d      = pend_q;
        next_seq_d  = next_seq_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_seq_d   = rsp_seq_q;
        rsp_wr_d    = rsp_wr_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;

        if (retire) begin
            pend_d[rin_seq] = 1'b0;
            rsp_valid_d     = 1'b1;
            rsp_err_d       = own_bounce;
            rsp_seq_d       = rin_seq;
            rsp_wr_d        = rin_wr;
            rsp_addr_d      = {rin_waddr, 2'b00};
            rsp_data_d      = own_bounce ? DATA_W'(0) : rin_data;
        end

        if (issue) begin
            rout_d             = {1'b1, 1'b1, req_wr, MASTER_ID, req_mask,
                                  req_addr[23:2], next_seq_q, req_wdata};
            pend_d[next_seq_q] = 1'b1;
            next_seq_d         = next_seq_q + SEQ_W'(1);
        end else if (own_pkt) begin
            rout_d = PKT_W'(0);
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rin_q       <= PKT_W'(0);
            rout_q      <= PKT_W'(0);
            pend_q      <= TAGS'(0);
            next_seq_q  <= SEQ_W'(0);
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_seq_q   <= SEQ_W'(0);
            rsp_wr_q    <= 1'b0;
            rsp_addr_q  <= ADDR_W'(0);
            rsp_data_q  <= DATA_W'(0);
        end else begin
            rin_q       <= rcn_in;
            rout_q      <= rout_d;
            pend_q      <= pend_d;
            next_seq_q  <= next_seq_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_seq_q   <= rsp_seq_d;
            rsp_wr_q    <= rsp_wr_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: doc/rcn_master.md
# rcn_master

Ring-bus (rcn) initiator. Accepts word read/write requests from a local client, inserts them into free ring slots, and tracks up to four outstanding transactions by a 2-bit sequence tag. It removes its own responses (and its own unclaimed requests) from the ring and returns them to the client. It sits on the same 69-bit ring as rcn slaves and is the requesting end of their protocol.

## Interface

Parameters:
- MASTER_ID, 6'd1, this initiator's ring ID; must be unique on the ring.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rcn_in  in  69  ring input from the upstream node.
- rcn_out  out  69  ring output to the downstream node (registered).
- req_valid  in  1  client request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_wr  in  1  1 = write, 0 = read.
- req_mask  in  4  byte enables.
- req_addr  in  24  byte address; bits [1:0] ignored.
- req_wdata  in  32  write data.
- req_seq  out  2  tag assigned to the request accepted this cycle.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_err  out  1  1 = request returned unclaimed.
- rsp_seq  out  2  tag of the completed request.
- rsp_wr  out  1  completed request was a write.
- rsp_addr  out  24  word address of the completed request, bits [1:0] = 0.
- rsp_data  out  32  read data; 0 when rsp_err = 1.
- busy  out  1  at least one transaction outstanding.

## Operation

- Packet fields: [68] valid, [67] 1 = request / 0 = response, [66] wr, [65:60] master ID, [59:56] mask, [55:34] addr[23:2], [33:32] seq, [31:0] data.
- Stage 1: rin <= rcn_in every cycle. All decisions use rin.
- Decode on rin: own_rsp = valid & ~req & id == MASTER_ID; own_bounce = valid & req & id == MASTER_ID; slot_free = ~rin[68] | own_rsp | own_bounce.
- Tracking: pend[3:0] (one bit per tag), next_seq (2-bit counter).
- req_ready = slot_free & ~pend[next_seq]. This is combinational from rin and the registered state.
- issue = req_valid & req_ready. rout <= {1, 1, req_wr, MASTER_ID, req_mask, req_addr[23:2], next_seq, req_wdata}. pend[next_seq] set. next_seq increments modulo 4, wrapping 3 -> 0. req_seq = next_seq.
- No issue and own_rsp or own_bounce: rout <= 69'd0, so the slot is freed.
- Otherwise: rout <= rin (pass-through, including other masters' traffic).
- own_rsp with pend[seq] = 1: next cycle rsp_valid = 1, rsp_err = 0, and the rsp_* fields are taken from rin with rsp_data = rin[31:0]. pend[seq] cleared.
- own_rsp with pend[seq] = 0 (stray): the packet is still removed. No rsp_valid. pend is unchanged.
- own_bounce (no slave claimed the request): handled the same as own_rsp, but rsp_err = 1 and rsp_data = 0. pend[seq] cleared.
- Same cycle retire and issue: legal. The retired slot carries the new request. Clear and set always target different tags, because ready needs ~pend[next_seq].
- busy = |pend.
- Reset: rin, rout, pend, next_seq and all rsp_* outputs go to 0. Reset mid-transaction drops all tracking. Responses that arrive later for pre-reset tags count as stray and are removed silently.

## Timing

- Ring latency rcn_in -> rcn_out is 2 cycles for pass-through traffic.
- Request accepted at edge N appears on rcn_out after edge N.
- Own response arriving on rcn_in before edge M: captured in rin at M, rsp_valid high after M+1 for one cycle. rcn_out is 0 after M+1 unless that slot is reused for a new issue.
- Sustained issue rate: one request per cycle while free slots arrive and fewer than 4 are outstanding.
- req_ready may toggle every cycle. The client must hold request fields stable until accepted.
- Reset values: rcn_out = 0, req_ready = 0 while rin is reset and then follows slot_free, rsp_valid = 0, busy = 0, req_seq = 0.

## Test plan

- Loopback with one slave at 0x001000: read 0x001004. Expect a request on rcn_out with seq 0. The slave returns 0xCAFEF00D, giving rsp_valid with seq 0, rsp_addr 0x001004, rsp_data 0xCAFEF00D, err 0. busy returns to 0.
- Idle ring, hold req_valid for 6 write requests with no slave responding yet. Expect 4 issues with tags 0, 1, 2, 3; req_ready = 0 on the 5th; busy = 1. Retire tag 0 and expect the 5th issue with tag 0 (counter wrap).
- Full ring of another master's packets (valid, id 2). Expect req_ready = 0 and every packet passed bit-exact with 2-cycle latency.
- Address with no slave (ring loops rcn_out -> rcn_in): the request returns. Expect rsp_err = 1, rsp_data = 0, matching seq, and rcn_out slot zeroed.
- Own response and new request in the same cycle. Expect rsp_valid for the old tag, and the new packet placed in that slot with the next tag.
- Reset asserted with 2 outstanding, then the stale responses injected. Expect removal, no rsp_valid, busy = 0, and next request tagged 0.
